// File: rtl/ir_pkg.sv
// -----------------------------------------------------------------------------
// ir_pkg
// Shared definitions for the NEC infrared decoder: the decoder state
// encoding, the nominal NEC timing thresholds in microseconds, and a helper
// that checks the address/command inverse bytes of a received frame.
// No ports (package).
// -----------------------------------------------------------------------------
package ir_pkg;

   // Decoder states, in the order a normal frame walks through them
   typedef enum logic [2:0] {
      IDLE,
      LEAD_H,
      LEAD_L,
      DATA,
      CHECK,
      REPEAT
   } ir_state_e;

   // Minimum durations (us) that classify marks and spaces
   localparam int unsigned LEAD_MARK_MIN_US  = 8000;
   localparam int unsigned HDR_SPACE_MIN_US  = 4000;
   localparam int unsigned RPT_SPACE_MIN_US  = 2000;
   localparam int unsigned BIT1_SPACE_MIN_US = 1000;

   // True when byte1 is the complement of byte0 and byte3 of byte2
   function automatic logic inv_ok(input logic [31:0] w);
      return (w[15:8] == ~w[7:0]) && (w[31:24] == ~w[23:16]);
   endfunction

endpackage

// File: rtl/ir_tick_gen.sv
// -----------------------------------------------------------------------------
// ir_tick_gen
// Free-running divider that produces a one-cycle enable every CLK_DIV clocks.
// With the default CLK_DIV this is a 1 us tick for the duration counter.
// Ports:
//   clk    - system clock
//   rst    - synchronous active-high reset (divider restarts at 0)
//   o_tick - one-cycle enable when the divider reaches CLK_DIV-1
// -----------------------------------------------------------------------------
module ir_tick_gen #(
   parameter int unsigned CLK_DIV = 50
) (
   input  logic clk,
   input  logic rst,
   output logic o_tick
);

   localparam int unsigned W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

   logic [W-1:0] div_q;
   logic [W-1:0] div_d;

   // Count 0..CLK_DIV-1 and wrap; the tick is the wrap cycle itself
   always_comb begin
      div_d = div_q + 1'b1;
      if (div_q == LAST) begin
         div_d = '0;
      end
   end

   // Divider register
   always_ff @(posedge clk) begin
      if (rst) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

   assign o_tick = (div_q == LAST);

endmodule

// File: rtl/ir_nec_dec.sv
// -----------------------------------------------------------------------------
// ir_nec_dec
// NEC infrared remote decoder. Measures mark/space durations in microsecond
// ticks, recognises the leader, 32 data bits and the repeat code, and checks
// the inverse bytes of each frame.
// Ports:
//   clk      - system clock
//   rst      - synchronous active-high reset
//   i_ir_rxb - asynchronous IR receiver line
//   o_data   - last accepted frame, first received bit in bit 0
//   o_addr   - o_data[7:0]
//   o_cmd    - o_data[23:16]
//   o_valid  - one-cycle pulse on an accepted frame
//   o_repeat - one-cycle pulse on an accepted repeat code
//   o_err    - one-cycle pulse on a rejected frame or timeout
//   o_busy   - high whenever the decoder is not idle
// The *_MIN_US parameters default to the NEC values and exist so the timing
// can be scaled down for fast simulation.
// -----------------------------------------------------------------------------
module ir_nec_dec
   import ir_pkg::*;
#(
   parameter int unsigned CLK_DIV           = 50,
   parameter int unsigned RX_INV            = 1,
   parameter int unsigned CHECK_INV         = 1,
   parameter int unsigned TIMEOUT_US        = 12000,
   parameter int unsigned LEAD_MARK_MIN     = LEAD_MARK_MIN_US,
   parameter int unsigned HDR_SPACE_MIN     = HDR_SPACE_MIN_US,
   parameter int unsigned RPT_SPACE_MIN     = RPT_SPACE_MIN_US,
   parameter int unsigned BIT1_SPACE_MIN    = BIT1_SPACE_MIN_US
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_ir_rxb,
   output logic [31:0] o_data,
   output logic [7:0]  o_addr,
   output logic [7:0]  o_cmd,
   output logic        o_valid,
   output logic        o_repeat,
   output logic        o_err,
   output logic        o_busy
);

   localparam logic IDLE_LVL = (RX_INV != 0);

   logic        tick;
   logic        rx_meta_q, rx_sync_q, mark_q;
   logic        mark, rise, fall;
   logic [15:0] cnt_q, cnt_d;
   ir_state_e   state_q, state_d;
   logic [31:0] shadow_q, shadow_d;
   logic [31:0] data_q, data_d;
   logic [4:0]  bit_q, bit_d;
   logic        seen_q, seen_d;
   logic        valid_q, valid_d;
   logic        rpt_q, rpt_d;
   logic        err_q, err_d;
   logic [31:0] word;
   logic        timeout;

   ir_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk    (clk),
      .rst    (rst),
      .o_tick (tick)
   );

   // Synchroniser for the asynchronous line plus the delayed mark used for
   // edge detection. The flops reset to the idle line level so that leaving
   // reset never looks like a mark edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q <= IDLE_LVL;
         rx_sync_q <= IDLE_LVL;
         mark_q    <= 1'b0;
      end else begin
         rx_meta_q <= i_ir_rxb;
         rx_sync_q <= rx_meta_q;
         mark_q    <= mark;
      end
   end

   assign mark = (RX_INV != 0) ? ~rx_sync_q : rx_sync_q;
   assign rise = mark & ~mark_q;
   assign fall = ~mark & mark_q;

   // Duration counter: restarts on every edge, counts ticks, sticks at max
   always_comb begin
      cnt_d = cnt_q;
      if (rise | fall) begin
         cnt_d = '0;
      end else if (tick && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   assign timeout = (state_q != IDLE) && (cnt_q > 16'(TIMEOUT_US));

   // Next-state and pulse logic. The frame decision is made on the stop-bit
   // rise, so the result is registered on entry to CHECK and o_valid/o_data
   // appear together during the single CHECK cycle.
   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      data_d   = data_q;
      bit_d    = bit_q;
      seen_d   = seen_q;
      valid_d  = 1'b0;
      rpt_d    = 1'b0;
      err_d    = 1'b0;
      word     = shadow_q;
      if (timeout) begin
         state_d  = IDLE;
         err_d    = 1'b1;
         shadow_d = '0;
         bit_d    = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (rise) state_d = LEAD_H;
            end
            LEAD_H: begin
               if (fall) begin
                  state_d = (cnt_q >= 16'(LEAD_MARK_MIN)) ? LEAD_L : IDLE;
               end
            end
            LEAD_L: begin
               if (rise) begin
                  if (cnt_q >= 16'(HDR_SPACE_MIN)) begin
                     state_d  = DATA;
                     shadow_d = '0;
                     bit_d    = '0;
                  end else if (cnt_q >= 16'(RPT_SPACE_MIN)) begin
                     state_d = REPEAT;
                  end else begin
                     state_d = IDLE;
                     err_d   = 1'b1;
                  end
               end
            end
            DATA: begin
               if (rise) begin
                  word[bit_q] = (cnt_q >= 16'(BIT1_SPACE_MIN));
                  shadow_d    = word;
                  bit_d       = bit_q + 5'd1;
                  if (bit_q == 5'd31) begin
                     state_d = CHECK;
                     if ((CHECK_INV == 0) || inv_ok(word)) begin
                        data_d  = word;
                        valid_d = 1'b1;
                        seen_d  = 1'b1;
                     end else begin
                        err_d = 1'b1;
                     end
                  end
               end
            end
            CHECK: begin
               state_d = IDLE;
            end
            REPEAT: begin
               if (fall) begin
                  state_d = IDLE;
                  rpt_d   = seen_q;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State, counter, frame and pulse registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         shadow_q <= '0;
         data_q   <= '0;
         bit_q    <= '0;
         seen_q   <= 1'b0;
         valid_q  <= 1'b0;
         rpt_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         data_q   <= data_d;
         bit_q    <= bit_d;
         seen_q   <= seen_d;
         valid_q  <= valid_d;
         rpt_q    <= rpt_d;
         err_q    <= err_d;
      end
   end

   assign o_data   = data_q;
   assign o_addr   = data_q[7:0];
   assign o_cmd    = data_q[23:16];
   assign o_valid  = valid_q;
   assign o_repeat = rpt_q;
   assign o_err    = err_q;
   assign o_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_ir_nec_dec.sv
// -----------------------------------------------------------------------------
// tb_ir_nec_dec
// Drives two decoders from one IR line: dutA enforces the inverse bytes,
// dutB does not. Timing is scaled down by 100 (1 tick = 100 us nominal) so
// whole frames fit in a short run. Expected pulses are queued when stimulus
// is driven and matched when the decoders pulse.
// -----------------------------------------------------------------------------
module tb_ir_nec_dec;

   localparam int CLK_DIV = 5;
   localparam int TIMEOUT = 120;
   localparam int T_LEAD_MARK = 90;
   localparam int T_LEAD_SPACE = 45;
   localparam int T_RPT_SPACE = 22;
   localparam int T_BIT_MARK = 6;
   localparam int T_ZERO = 6;
   localparam int T_ONE = 17;
   localparam logic MARK = 1'b0;
   localparam logic SPACE = 1'b1;
   localparam int K_VALID = 0;
   localparam int K_REPEAT = 1;
   localparam int K_ERR = 2;

   typedef struct {
      int          kind;
      logic [31:0] data;
   } evt_t;

   typedef struct {
      logic [7:0]  addr;
      logic [7:0]  naddr;
      logic [7:0]  cmd;
      logic [7:0]  ncmd;
      int          aKind;
      logic [31:0] aData;
      logic [31:0] bData;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        rxb;
   logic [31:0] dataA, dataB;
   logic [7:0]  addrA, addrB, cmdA, cmdB;
   logic        validA, validB, repeatA, repeatB, errA, errB, busyA, busyB;

   evt_t        expA[$];
   evt_t        expB[$];
   vec_t        vecs[5];
   int          compared = 0;
   int          mismatched = 0;
   logic [31:0] lastA, lastB;
   logic        seenA, seenB;
   longint      cycle = 0;
   longint      errCycleA = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   ir_nec_dec #(
      .CLK_DIV(CLK_DIV), .RX_INV(1), .CHECK_INV(1), .TIMEOUT_US(TIMEOUT),
      .LEAD_MARK_MIN(80), .HDR_SPACE_MIN(40), .RPT_SPACE_MIN(20), .BIT1_SPACE_MIN(10)
   ) dutA (
      .clk(clk), .rst(rst), .i_ir_rxb(rxb),
      .o_data(dataA), .o_addr(addrA), .o_cmd(cmdA),
      .o_valid(validA), .o_repeat(repeatA), .o_err(errA), .o_busy(busyA)
   );

   ir_nec_dec #(
      .CLK_DIV(CLK_DIV), .RX_INV(1), .CHECK_INV(0), .TIMEOUT_US(TIMEOUT),
      .LEAD_MARK_MIN(80), .HDR_SPACE_MIN(40), .RPT_SPACE_MIN(20), .BIT1_SPACE_MIN(10)
   ) dutB (
      .clk(clk), .rst(rst), .i_ir_rxb(rxb),
      .o_data(dataB), .o_addr(addrB), .o_cmd(cmdB),
      .o_valid(validB), .o_repeat(repeatB), .o_err(errB), .o_busy(busyB)
   );

   task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Match one observed pulse of decoder `which` against its queue
   task automatic observe(input int which, input logic v, input logic r, input logic e,
                          input logic [31:0] d);
      evt_t ev;
      bit   have;
      int   n;
      string tag;
      if (v | r | e) begin
         tag = (which == 0) ? "A" : "B";
         n = int'(v) + int'(r) + int'(e);
         compare({"pulse exclusivity ", tag}, n, 1);
         have = 0;
         if (which == 0) begin
            if (expA.size() > 0) begin ev = expA.pop_front(); have = 1; end
         end else begin
            if (expB.size() > 0) begin ev = expB.pop_front(); have = 1; end
         end
         if (!have) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected pulse %s: got v/r/e=%b%b%b, expected none", tag, v, r, e);
         end else begin
            compare({"pulse kind ", tag}, v ? K_VALID : (r ? K_REPEAT : K_ERR), ev.kind);
            compare({"data at pulse ", tag}, d, ev.data);
         end
      end
   endtask

   always @(negedge clk) begin
      observe(0, validA, repeatA, errA, dataA);
      observe(1, validB, repeatB, errB, dataB);
      if (errA) errCycleA <= cycle;
   end

   task automatic holdTicks(input logic level, input int ticks);
      rxb = level;
      repeat (ticks * CLK_DIV) @(negedge clk);
   endtask

   task automatic sendBits(input logic [31:0] w, input int nbits);
      for (int k = 0; k < nbits; k++) begin
         holdTicks(MARK, T_BIT_MARK);
         holdTicks(SPACE, w[k] ? T_ONE : T_ZERO);
      end
   endtask

   task automatic sendRepeat();
      holdTicks(MARK, T_LEAD_MARK);
      holdTicks(SPACE, T_RPT_SPACE);
      holdTicks(MARK, T_BIT_MARK);
      holdTicks(SPACE, 20);
   endtask

   // Queue the expected pulses for one frame, then drive it on the line
   task automatic applyStimulus(input vec_t v);
      logic [31:0] w;
      w = {v.ncmd, v.cmd, v.naddr, v.addr};
      expA.push_back('{v.aKind, v.aData});
      if (v.aKind == K_VALID) seenA = 1'b1;
      lastA = v.aData;
      expB.push_back('{K_VALID, v.bData});
      seenB = 1'b1;
      lastB = v.bData;
      holdTicks(MARK, T_LEAD_MARK);
      holdTicks(SPACE, T_LEAD_SPACE);
      sendBits(w, 32);
      holdTicks(MARK, T_BIT_MARK);
      holdTicks(SPACE, 30);
   endtask

   task automatic checkDrained(input string name);
      compare({name, " queue A drained"}, expA.size(), 0);
      compare({name, " queue B drained"}, expB.size(), 0);
   endtask

   // Compare the static outputs of both decoders with the model
   task automatic checkOutput(input string name);
      compare({name, " data A"}, dataA, lastA);
      compare({name, " addr A"}, {24'd0, addrA}, {24'd0, lastA[7:0]});
      compare({name, " cmd A"}, {24'd0, cmdA}, {24'd0, lastA[23:16]});
      compare({name, " pulses A"}, {29'd0, validA, repeatA, errA}, 0);
      compare({name, " busy A"}, {31'd0, busyA}, 0);
      compare({name, " data B"}, dataB, lastB);
      compare({name, " addr B"}, {24'd0, addrB}, {24'd0, lastB[7:0]});
      compare({name, " cmd B"}, {24'd0, cmdB}, {24'd0, lastB[23:16]});
      compare({name, " pulses B"}, {29'd0, validB, repeatB, errB}, 0);
      compare({name, " busy B"}, {31'd0, busyB}, 0);
   endtask

   task automatic waitIdle(input string name, input int budget);
      int n = 0;
      while ((busyA | busyB) && (n < budget)) begin
         @(negedge clk);
         n++;
      end
      compare({name, " idle within budget"}, {31'd0, busyA | busyB}, 0);
   endtask

   initial begin
      longint lastEdge;
      longint delta;
      vecs[0] = '{8'h00, 8'hFF, 8'h45, 8'hBA, K_VALID, 32'hBA45FF00, 32'hBA45FF00};
      vecs[1] = '{8'h00, 8'hFF, 8'h45, 8'hBB, K_ERR,   32'hBA45FF00, 32'hBB45FF00};
      vecs[2] = '{8'h12, 8'hED, 8'h34, 8'hCB, K_VALID, 32'hCB34ED12, 32'hCB34ED12};
      vecs[3] = '{8'hA5, 8'h5A, 8'h00, 8'hFF, K_VALID, 32'hFF005AA5, 32'hFF005AA5};
      vecs[4] = '{8'h12, 8'h34, 8'h56, 8'h78, K_ERR,   32'hFF005AA5, 32'h78563412};
      lastA = '0; lastB = '0; seenA = 1'b0; seenB = 1'b0;

      rxb = SPACE;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset");
      rst = 1'b0;

      $display("[TB] repeat code before any frame");
      sendRepeat();
      checkDrained("early repeat");
      checkOutput("early repeat");

      $display("[TB] short mark noise");
      holdTicks(MARK, 30);
      holdTicks(SPACE, 20);
      waitIdle("noise", 100);
      checkDrained("noise");
      checkOutput("noise");

      $display("[TB] frame table");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(vecs[i]);
         waitIdle("frame", 100);
         checkDrained("frame");
         checkOutput("frame");
      end

      $display("[TB] repeat after valid frame");
      if (seenA) expA.push_back('{K_REPEAT, lastA});
      if (seenB) expB.push_back('{K_REPEAT, lastB});
      sendRepeat();
      checkDrained("repeat");
      checkOutput("repeat");

      $display("[TB] truncated frame");
      expA.push_back('{K_ERR, lastA});
      expB.push_back('{K_ERR, lastB});
      holdTicks(MARK, T_LEAD_MARK);
      holdTicks(SPACE, T_LEAD_SPACE);
      sendBits(32'hBA45FF00, 20);
      holdTicks(MARK, T_BIT_MARK);
      rxb = SPACE;
      lastEdge = cycle;
      waitIdle("truncation", (TIMEOUT + 20) * CLK_DIV);
      repeat (2) @(negedge clk);
      checkDrained("truncation");
      delta = errCycleA - lastEdge;
      compared++;
      if (delta < longint'(TIMEOUT * CLK_DIV) || delta > longint'((TIMEOUT + 6) * CLK_DIV)) begin
         mismatched++;
         $display("[TB] FAIL timeout latency: got %0d cycles, expected %0d..%0d",
                  delta, TIMEOUT * CLK_DIV, (TIMEOUT + 6) * CLK_DIV);
      end
      checkOutput("truncation");

      $display("[TB] reset in the middle of a frame");
      holdTicks(MARK, T_LEAD_MARK);
      holdTicks(SPACE, T_LEAD_SPACE);
      sendBits(32'hBA45FF00, 10);
      holdTicks(MARK, 3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      lastA = '0; lastB = '0; seenA = 1'b0; seenB = 1'b0;
      checkOutput("mid-frame reset");
      holdTicks(SPACE, 30);
      checkDrained("after reset");
      applyStimulus(vecs[0]);
      waitIdle("post-reset frame", 100);
      checkDrained("post-reset frame");
      checkOutput("post-reset frame");
      if (seenA) expA.push_back('{K_REPEAT, lastA});
      if (seenB) expB.push_back('{K_REPEAT, lastB});
      sendRepeat();
      checkDrained("post-reset repeat");
      checkOutput("post-reset repeat");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
